// File: rtl/nn_pkg.sv
// Shared types and constants for the neuron datapath: operand widths, FSM states, saturation limits.
package nn_pkg;

  localparam int unsigned ACT_WIDTH  = 8;
  localparam int unsigned PROD_WIDTH = 2 * ACT_WIDTH;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_e;

  // Saturation bounds for a signed accumulator of a given width.
  function automatic logic [127:0] sat_max_f(input int unsigned w);
    logic [127:0] v;
    v = '0;
    for (int unsigned i = 0; i < 127; i++) begin
      if (i < w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [127:0] sat_min_f(input int unsigned w);
    return ~sat_max_f(w);
  endfunction

endpackage

// File: rtl/neuron_acc_sat_add.sv
// Combinational signed saturating adder; clamps the sum to the IN_WIDTH-bit signed range.
module sat_add
  import nn_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0] a_i,
  input  logic signed [IN_WIDTH-1:0] b_i,
  output logic signed [IN_WIDTH-1:0] sum_c_o
);

  localparam logic [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'(sat_max_f(IN_WIDTH));
  localparam logic [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(sat_min_f(IN_WIDTH));

  logic signed [IN_WIDTH:0] full_c;
  logic                     ovf_c;

  // One guard bit is enough: overflow shows as a disagreement between the top two bits.
  always_comb begin
    full_c  = (IN_WIDTH + 1)'(a_i) + (IN_WIDTH + 1)'(b_i);
    ovf_c   = full_c[IN_WIDTH] ^ full_c[IN_WIDTH-1];
    sum_c_o = full_c[IN_WIDTH-1:0];
    if (ovf_c) begin
      sum_c_o = full_c[IN_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/neuron_acc.sv
// Multiply-accumulate for one neuron: N_INPUTS act*wgt beats plus bias, saturating, with a
// valid/ready result handshake that blocks new beats until the sum is taken.
module neuron_acc
  import nn_pkg::*;
#(
  parameter int unsigned N_INPUTS = 8,
  parameter int unsigned IN_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [ACT_WIDTH-1:0] act,
  input  logic signed [ACT_WIDTH-1:0] wgt,
  input  logic signed [IN_WIDTH-1:0]  bias,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [IN_WIDTH-1:0]  acc_out
);

  localparam int unsigned CNT_W = $clog2(N_INPUTS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  state_e                       state_q, state_d;
  logic        [CNT_W-1:0]      count_q, count_d;
  logic signed [IN_WIDTH-1:0]   acc_q, acc_d;
  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;

  logic                         accept_c;
  logic                         last_c;
  logic signed [PROD_WIDTH-1:0] prod_c;
  logic signed [IN_WIDTH-1:0]   addend_c;
  logic signed [IN_WIDTH-1:0]   sum_c;

  assign accept_c = in_valid && in_ready_q;
  assign last_c   = (count_q == LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept_c && last_c) state_d = ST_DONE;
      ST_DONE:  if (out_ready)          state_d = ST_ACCUM;
      default:                          state_d = ST_ACCUM;
    endcase
  end

  // Handshake outputs follow the state being entered, so they are registered alongside it.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    case (state_d)
      ST_ACCUM: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
      ST_DONE: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Exact 8x8 signed product; the first beat of a neuron starts from bias instead of acc.
  always_comb begin
    prod_c   = PROD_WIDTH'(act) * PROD_WIDTH'(wgt);
    addend_c = (count_q == '0) ? bias : acc_q;
  end

  sat_add #(
    .IN_WIDTH(IN_WIDTH)
  ) u_sat_add (
    .a_i    (addend_c),
    .b_i    (IN_WIDTH'(prod_c)),
    .sum_c_o(sum_c)
  );

  // Datapath next-state
  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (accept_c) begin
      acc_d   = sum_c;
      count_d = last_c ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_neuron_acc.sv
// Scoreboard bench for neuron_acc: instance 0 uses N_INPUTS=4, instance 1 uses N_INPUTS=8.
module tb_neuron_acc;

  localparam int unsigned W  = 16;
  localparam int unsigned NA = 4;
  localparam int unsigned NB = 8;
  localparam int MAXV = (2 ** (W - 1)) - 1;
  localparam int MINV = -(2 ** (W - 1));

  typedef struct {
    int acc;
    int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid  [2];
  logic                in_ready  [2];
  logic                out_valid [2];
  logic                out_ready [2];
  logic signed [7:0]   act       [2];
  logic signed [7:0]   wgt       [2];
  logic signed [W-1:0] bias      [2];
  logic signed [W-1:0] acc_out   [2];

  neuron_acc #(.N_INPUTS(NA), .IN_WIDTH(W)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .act(act[0]), .wgt(wgt[0]), .bias(bias[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .acc_out(acc_out[0])
  );

  neuron_acc #(.N_INPUTS(NB), .IN_WIDTH(W)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .act(act[1]), .wgt(wgt[1]), .bias(bias[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .acc_out(acc_out[1])
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  int   beat_a [64];
  int   beat_w [64];
  bit   was_valid [2];
  int   held      [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: plain integer sum with clamping after every addition.
  function automatic int model(input int b, input int n);
    int s;
    s = b;
    for (int i = 0; i < n; i++) begin
      s = s + beat_a[i] * beat_w[i];
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
    end
    return s;
  endfunction

  // Monitor: latency on first valid, stability while held, value on handshake.
  task automatic mon(input int k);
    exp_t e;
    bit   have;
    have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
    if (have) e = (k == 0) ? sb0[0] : sb1[0];
    if (!rst_n) begin
      was_valid[k] = 1'b0;
      return;
    end
    if (out_valid[k] && !was_valid[k]) begin
      check($sformatf("valid_expected_%0d", k), int'(have), 1);
      if (have) check($sformatf("latency_%0d", k), cyc, e.due);
      held[k] = int'(acc_out[k]);
    end else if (out_valid[k]) begin
      check($sformatf("hold_stable_%0d", k), int'(acc_out[k]), held[k]);
    end
    if (out_valid[k]) check($sformatf("in_ready_low_%0d", k), int'(in_ready[k]), 0);
    if (out_valid[k] && out_ready[k]) begin
      if (have) begin
        check($sformatf("acc_out_%0d", k), int'(acc_out[k]), e.acc);
        if (k == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
      end
      was_valid[k] = 1'b0;
    end else begin
      was_valid[k] = out_valid[k];
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic tick(input int k, input bit rnd_rdy);
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready[k] = 1'($urandom_range(0, 1));
  endtask

  // Present n beats from beat_a/beat_w; bias is junk on all but the first beat.
  task automatic send(input int k, input int b, input int n, input int gap_pct,
                      input bit rnd_rdy, input bit push);
    bit ok;
    int guard;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      in_valid[k] = 1'b0;
      while ($urandom_range(0, 99) < gap_pct) begin
        act[k] = 8'($urandom);
        tick(k, rnd_rdy);
      end
      in_valid[k] = 1'b1;
      act[k]  = 8'(beat_a[i]);
      wgt[k]  = 8'(beat_w[i]);
      bias[k] = (i == 0) ? W'(b) : W'($urandom);
      guard = 0;
      do begin
        @(negedge clk);
        ok = in_ready[k];
        tick(k, rnd_rdy);
        guard++;
      end while (!ok && guard < 200);
      if (!ok) check("accept_timeout", 0, 1);
      if (push && i == n - 1) begin
        e.acc = model(b, n);
        e.due = cyc;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int guard;
    guard = 0;
    out_ready[k] = 1'b1;
    while (((k == 0) ? sb0.size() : sb1.size()) > 0 && guard < 200) begin
      tick(k, 1'b0);
      guard++;
    end
    check("drain_timeout", (k == 0) ? sb0.size() : sb1.size(), 0);
  endtask

  task automatic fill(input int n, input int a, input int w);
    for (int i = 0; i < n; i++) begin
      beat_a[i] = a;
      beat_w[i] = w;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      beat_a[i] = $signed(8'($urandom));
      beat_w[i] = $signed(8'($urandom));
    end
  endtask

  task automatic fill_basic();
    beat_a[0] = 3;  beat_w[0] = 4;
    beat_a[1] = -2; beat_w[1] = 5;
    beat_a[2] = 1;  beat_w[2] = 1;
    beat_a[3] = 0;  beat_w[3] = 7;
  endtask

  task automatic check_reset_state(input int k, input string tag);
    check($sformatf("%s_out_valid_%0d", tag, k), int'(out_valid[k]), 0);
    check($sformatf("%s_in_ready_%0d", tag, k), int'(in_ready[k]), 1);
    check($sformatf("%s_acc_out_%0d", tag, k), int'(acc_out[k]), 0);
  endtask

  initial begin
    int wait_g;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      act[k] = '0; wgt[k] = '0; bias[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_reset_state(k, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic sum on the 4-beat instance, then the same with gaps and random out_ready.
    fill_basic();
    send(0, 10, NA, 0, 1'b0, 1'b1);
    drain(0);
    fill_basic();
    send(0, 10, NA, 40, 1'b1, 1'b1);
    drain(0);
    for (int t = 0; t < 20; t++) begin
      fill_rand(NA);
      send(0, $signed(16'($urandom)), NA, 20, 1'b1, 1'b1);
    end
    drain(0);

    // Saturation on the 8-beat instance.
    fill(NB, 127, 127);
    send(1, 32000, NB, 0, 1'b0, 1'b1);
    drain(1);
    fill(NB, -128, 127);
    send(1, -32768, NB, 0, 1'b0, 1'b1);
    drain(1);
    fill(NB, -128, -128);
    send(1, 0, NB, 10, 1'b1, 1'b1);
    drain(1);

    // Backpressure: result held while in_valid stays high with junk beats.
    out_ready[1] = 1'b0;
    fill_rand(NB);
    send(1, 123, NB, 0, 1'b0, 1'b1);
    in_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      act[1] = 8'($urandom); wgt[1] = 8'($urandom);
      tick(1, 1'b0);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    tick(1, 1'b0);
    fill(NB, 2, 3);
    send(1, -5, NB, 0, 1'b0, 1'b1);
    drain(1);

    // Reset after 3 of 8 beats discards the partial sum.
    fill(3, 50, 50);
    send(1, 1000, 3, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state(1, "midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill(NB, 1, 1);
    send(1, 0, NB, 0, 1'b0, 1'b1);
    drain(1);

    // Reset in DONE together with out_ready=1: the pending result is dropped.
    out_ready[1] = 1'b0;
    fill_rand(NB);
    send(1, 77, NB, 0, 1'b0, 1'b1);
    wait_g = 0;
    while (!out_valid[1] && wait_g < 20) begin
      tick(1, 1'b0);
      wait_g++;
    end
    check("done_reached", int'(out_valid[1]), 1);
    rst_n = 1'b0;
    out_ready[1] = 1'b1;
    void'(sb1.pop_back());
    @(posedge clk);
    @(negedge clk);
    check_reset_state(1, "donereset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill_rand(NB);
    send(1, -300, NB, 30, 1'b1, 1'b1);
    drain(1);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
